dram_fill_arbiter: RTL and testbench
====================================

# dram_fill_arbiter

Shares the single DRAM-cache fill/write channel among several requesters. Requesters include the read-miss handler's fill path (port 0, latency critical), the write-miss fill path and the host write-hit path. Each requester presents an {address, data} word with a valid/ready handshake. The block grants one word per cycle into a one-entry registered output stage: port 0 has fixed priority, the other ports are round-robin, and an aging counter prevents any port from starving.

## Interface
- `ADDR_WIDTH`, default `` `AXI_ADDR_WIDTH ``: address field width.
- `DATA_WIDTH`, default `` `AXI_DATA_WIDTH ``: data field width.
- `WDATA_WIDTH`, default ADDR_WIDTH+DATA_WIDTH: packed word, {addr, data}, with addr in the MSBs.
- `NUM_REQ`, default 3: number of requesters, minimum 2.
- `STARVE_LIMIT`, default 4: waiting cycles after which a port is promoted.
- `SRC_WIDTH`, default $clog2(NUM_REQ): width of the source index.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  NUM_REQ  per-requester word valid.
- `ready_o`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `wdata_i`  in  NUM_REQ*WDATA_WIDTH  packed words; port i occupies slice [i*WDATA_WIDTH +: WDATA_WIDTH].
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  downstream (DRAM write scheduler) accept.
- `wdata_o`  out  WDATA_WIDTH  granted word.
- `src_o`  out  SRC_WIDTH  index of the port that supplied wdata_o.

## Operation
- **Output register states:** EMPTY (valid_o=0) and FULL (valid_o=1). The slot is "free" when `!valid_o | ready_i`.
- **When the slot is free**, exactly one winner is chosen among the asserted valid_i:
  1. Starved: the lowest index i≥1 with valid_i[i] and wait_cnt[i]==STARVE_LIMIT.
  2. Otherwise port 0, if valid_i[0].
  3. Otherwise round-robin over 1..NUM_REQ-1, starting at rr_ptr.
- **Winner handling:** ready_o[winner]=1, and the winner is accepted the same cycle.
  - On the next edge: wdata_o←wdata_i[winner], src_o←winner, valid_o←1.
- **No winner:** if the slot is free and no port is valid, valid_o←0 on the next edge.
- **Slot not free** (valid_o & !ready_i): ready_o=0 for all ports; wdata_o and src_o are held stable.
- **wait_cnt[i]** (i≥1, saturating at STARVE_LIMIT):
  - Increments when valid_i[i] & !ready_o[i].
  - Clears to 0 on accept or when valid_i[i]=0.
  - Port 0 has no counter.
- **rr_ptr** (range 1..NUM_REQ-1, reset 1):
  - After any grant to port w≥1 (round-robin or starved), rr_ptr←w+1, wrapping NUM_REQ-1→1.
  - Port-0 grants leave rr_ptr unchanged.
- **Simultaneous drain and accept:** when valid_o & ready_i and a new winner exists, the new word replaces the old one on the same edge, giving full throughput of 1 word/cycle.
- **Requesters** must hold valid_i and wdata_i stable until ready_o; the arbiter does not check this.

## Timing
- **Reset values:** valid_o=0, wdata_o=0, src_o=0, ready_o=0 (forced while rst=1), wait_cnt=0, rr_ptr=1.
- **Reset mid-operation:** a held output word is discarded at the reset edge and no accept occurs in that cycle.
- **Combinational paths:** ready_o depends combinationally on valid_i, ready_i and the internal state. valid_o, wdata_o and src_o come directly from flops.
- **Latency:** 1 cycle from an accept (valid_i&ready_o) to valid_o.
- **Fairness bound:** a port i≥1 waits at most STARVE_LIMIT + (NUM_REQ-2) granted cycles.
- **Width rules:** wait_cnt is $clog2(STARVE_LIMIT+1) bits. rr_ptr and src_o are SRC_WIDTH bits, and index arithmetic wraps modulo the legal range.

## Structure
- **Shared TYPEDEF package:** WDATA layout macros (addr in MSBs), NUM_REQ default, and named port indices (REQ_RMISS=0, REQ_WMISS=1, REQ_WHIT=2).
- **Sub-module:** one natural sub-module, `rr_picker`, a combinational rotate-priority encoder over a NUM_REQ-1 mask with a start pointer. It is reused by other schedulers in the design.

## Test plan
1. **Priority port alone.** After reset, valid_i=3'b001, wdata_i[0]=0xA5, ready_i=1 → ready_o=3'b001 at cycle 0; valid_o=1, wdata_o=0xA5, src_o=0 at cycle 1.
2. **Aging.** NUM_REQ=3, STARVE_LIMIT=4; valid_i=3'b011 held, ready_i=1 → port 0 accepted in cycles 0–3, port 1 accepted in cycle 4 (wait_cnt[1]=4), port 0 in cycle 5.
3. **Round-robin.** valid_i=3'b110 held, ready_i=1 → grants 1,2,1,2…; rr_ptr toggles 2,1,2.
4. **Backpressure.** FULL with ready_i=0 for 3 cycles while all ports are valid → ready_o=0 and wdata_o/src_o unchanged. The cycle ready_i=1 returns → new accept, and the new word appears on the next cycle with no bubble.
5. **Reset mid-operation.** FULL plus pending requests, rst=1 for 1 cycle → next cycle valid_o=0, no ready_o during reset, wait_cnt cleared. Port 1 then needs 4 fresh waiting cycles before it is promoted.

Source files
------------

// File: rtl/dram_fill_arbiter_pkg.sv
// rtl/dram_fill_arbiter_pkg.sv - shared defaults, word layout and port indices for the fill arbiter
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`define DFA_WORD(addr, data) {addr, data}
`define DFA_ADDR(word, dw) word[$bits(word)-1:dw]
`define DFA_DATA(word, dw) word[dw-1:0]

package dram_fill_arbiter_pkg;
    localparam int NUM_REQ_DEFAULT = 3;

    typedef enum int {
        REQ_RMISS = 0,
        REQ_WMISS = 1,
        REQ_WHIT  = 2
    } req_port_e;
endpackage

// File: rtl/dram_fill_arbiter_rr_picker.sv
// rtl/dram_fill_arbiter_rr_picker.sv - rotate-priority encoder: first set mask bit at or after start
module rr_picker #(
    parameter int N         = 2,
    parameter int PTR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         mask,
    input  logic [PTR_WIDTH-1:0] start,
    output logic                 found,
    output logic [PTR_WIDTH-1:0] idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && mask[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = PTR_WIDTH'((int'(start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/dram_fill_arbiter.sv
// rtl/dram_fill_arbiter.sv - fill/write channel arbiter: port 0 priority, round-robin rest, aging promotion
module dram_fill_arbiter
    import dram_fill_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int WDATA_WIDTH  = ADDR_WIDTH + DATA_WIDTH,
    parameter int NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int STARVE_LIMIT = 4,
    parameter int SRC_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             valid_i,
    output logic [NUM_REQ-1:0]             ready_o,
    input  logic [NUM_REQ*WDATA_WIDTH-1:0] wdata_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [WDATA_WIDTH-1:0]         wdata_o,
    output logic [SRC_WIDTH-1:0]           src_o
);
    localparam int                   CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [SRC_WIDTH-1:0] LAST      = SRC_WIDTH'(NUM_REQ - 1);
    localparam logic [SRC_WIDTH-1:0] ONE       = SRC_WIDTH'(1);

    logic [CNT_WIDTH-1:0]   wait_cnt [1:NUM_REQ-1];
    logic [SRC_WIDTH-1:0]   rr_ptr;
    logic                   slot_free, grant, starved_hit, rr_found;
    logic [SRC_WIDTH-1:0]   starved_idx, rr_idx, winner;
    logic [WDATA_WIDTH-1:0] win_word;

    // Picker works on ports 1..NUM_REQ-1 re-based to 0; rr_ptr is kept 1-based.
    rr_picker #(
        .N         (NUM_REQ - 1),
        .PTR_WIDTH (SRC_WIDTH)
    ) u_rr_picker (
        .mask  (valid_i[NUM_REQ-1:1]),
        .start (rr_ptr - ONE),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_comb begin
        slot_free   = !valid_o || ready_i;
        starved_hit = 1'b0;
        starved_idx = '0;
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            if (valid_i[i] && wait_cnt[i] == CNT_MAX) begin
                starved_hit = 1'b1;
                starved_idx = SRC_WIDTH'(i);
            end
        end
        grant  = 1'b0;
        winner = '0;
        if (slot_free && !rst) begin
            if (starved_hit) begin
                grant  = 1'b1;
                winner = starved_idx;
            end else if (valid_i[0]) begin
                grant  = 1'b1;
                winner = '0;
            end else if (rr_found) begin
                grant  = 1'b1;
                winner = rr_idx + ONE;
            end
        end
        ready_o  = '0;
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && winner == SRC_WIDTH'(i)) begin
                ready_o[i] = 1'b1;
                win_word   = wdata_i[i*WDATA_WIDTH +: WDATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wdata_o <= '0;
            src_o   <= '0;
            rr_ptr  <= ONE;
            for (int i = 1; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
            if (slot_free) begin
                valid_o <= grant;
                if (grant) begin
                    wdata_o <= win_word;
                    src_o   <= winner;
                    if (winner != '0) rr_ptr <= (winner == LAST) ? ONE : winner + ONE;
                end
            end
            for (int i = 1; i < NUM_REQ; i++) begin
                if (!valid_i[i] || ready_o[i]) wait_cnt[i] <= '0;
                else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_dram_fill_arbiter.sv
// tb/tb_dram_fill_arbiter.sv - scoreboard bench for dram_fill_arbiter
module tb_dram_fill_arbiter;
    import dram_fill_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int WW = AW + DW;
    localparam int NR = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] valid_i, ready_o;
    logic [NR*WW-1:0] wdata_i;
    logic          valid_o, ready_i;
    logic [WW-1:0] wdata_o;
    logic [SW-1:0] src_o;

    logic [WW-1:0]    wd [NR];
    logic [SW+WW-1:0] sb [$];
    int checks = 0;
    int errors = 0;
    int seq    = 0;

    assign wdata_i = {wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    dram_fill_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .STARVE_LIMIT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .wdata_i (wdata_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .wdata_o (wdata_o),
        .src_o   (src_o)
    );

    function automatic logic [SW-1:0] oh2idx(input logic [NR-1:0] oh);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = SW'(i);
        return r;
    endfunction

    function automatic logic [WW-1:0] mk(input int p, input int n);
        return `DFA_WORD(AW'(p + 1), DW'(n));
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_i = '0; ready_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 3'b111;
        @(negedge clk);
        checks++; if (ready_o !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++; if (wdata_o !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata_o); end
        checks++; if (src_o !== '0) begin errors++; $display("FAIL reset_src got %0d exp 0", src_o); end
        @(posedge clk); #1;
        rst = 1'b0; valid_i = '0;
    endtask

    task automatic test_priority();
        logic [NR-1:0] vi [2] = '{3'b001, 3'b000};
        logic [NR-1:0] er [2] = '{3'b001, 3'b000};
        logic [SW+WW-1:0] held = '0;
        logic got = 1'b0, have = 1'b0;
        wd[0] = 16'h00A5;
        for (int c = 0; c < 2; c++) begin
            valid_i = vi[c]; ready_i = 1'b1; rst = 1'b0;
            @(negedge clk);
            if (got) begin held = sb.pop_front(); have = 1'b1; end
            checks++;
            if (have ? ({valid_o, src_o, wdata_o} !== {1'b1, held}) : (valid_o !== 1'b0)) begin
                errors++; $display("FAIL priority_out c%0d got v=%0b src=%0d data=%h exp v=%0b src/data=%h", c, valid_o, src_o, wdata_o, have, held);
            end
            checks++;
            if (ready_o !== er[c]) begin errors++; $display("FAIL priority_ready c%0d got %b exp %b", c, ready_o, er[c]); end
            got = (er[c] != '0);
            if (got) sb.push_back({oh2idx(er[c]), wd[oh2idx(er[c])]});
            if (!got) have = 1'b0;
            @(posedge clk); #1;
            if (got) begin wd[oh2idx(er[c])] = mk(int'(oh2idx(er[c])), seq); seq++; end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] vi [5] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b000};
        logic [NR-1:0] er [5] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000};
        logic [SW+WW-1:0] held = '0;
        logic got = 1'b0, have = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_i = vi[c]; ready_i = 1'b1; rst = 1'b0;
            @(negedge clk);
            if (got) begin held = sb.pop_front(); have = 1'b1; end
            checks++;
            if (have ? ({valid_o, src_o, wdata_o} !== {1'b1, held}) : (valid_o !== 1'b0)) begin
                errors++; $display("FAIL rr_out c%0d got v=%0b src=%0d data=%h exp v=%0b src/data=%h", c, valid_o, src_o, wdata_o, have, held);
            end
            checks++;
            if (ready_o !== er[c]) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, ready_o, er[c]); end
            got = (er[c] != '0);
            if (got) sb.push_back({oh2idx(er[c]), wd[oh2idx(er[c])]});
            if (!got) have = 1'b0;
            @(posedge clk); #1;
            if (got) begin wd[oh2idx(er[c])] = mk(int'(oh2idx(er[c])), seq); seq++; end
        end
    endtask

    task automatic test_aging();
        logic [NR-1:0] vi [7] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
        logic [NR-1:0] er [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b000};
        logic [SW+WW-1:0] held = '0;
        logic got = 1'b0, have = 1'b0;
        for (int c = 0; c < 7; c++) begin
            valid_i = vi[c]; ready_i = 1'b1; rst = 1'b0;
            @(negedge clk);
            if (got) begin held = sb.pop_front(); have = 1'b1; end
            checks++;
            if (have ? ({valid_o, src_o, wdata_o} !== {1'b1, held}) : (valid_o !== 1'b0)) begin
                errors++; $display("FAIL aging_out c%0d got v=%0b src=%0d data=%h exp v=%0b src/data=%h", c, valid_o, src_o, wdata_o, have, held);
            end
            checks++;
            if (ready_o !== er[c]) begin errors++; $display("FAIL aging_ready c%0d got %b exp %b", c, ready_o, er[c]); end
            got = (er[c] != '0);
            if (got) sb.push_back({oh2idx(er[c]), wd[oh2idx(er[c])]});
            if (!got) have = 1'b0;
            @(posedge clk); #1;
            if (got) begin wd[oh2idx(er[c])] = mk(int'(oh2idx(er[c])), seq); seq++; end
        end
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] vi [7] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
        logic [NR-1:0] er [7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
        logic          rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [SW+WW-1:0] held = '0;
        logic got = 1'b0, have = 1'b0;
        for (int c = 0; c < 7; c++) begin
            valid_i = vi[c]; ready_i = rdy[c]; rst = 1'b0;
            @(negedge clk);
            if (got) begin held = sb.pop_front(); have = 1'b1; end
            checks++;
            if (have ? ({valid_o, src_o, wdata_o} !== {1'b1, held}) : (valid_o !== 1'b0)) begin
                errors++; $display("FAIL bp_out c%0d got v=%0b src=%0d data=%h exp v=%0b src/data=%h", c, valid_o, src_o, wdata_o, have, held);
            end
            checks++;
            if (ready_o !== er[c]) begin errors++; $display("FAIL bp_ready c%0d got %b exp %b", c, ready_o, er[c]); end
            got = (er[c] != '0);
            if (got) sb.push_back({oh2idx(er[c]), wd[oh2idx(er[c])]});
            if (!got && rdy[c]) have = 1'b0;
            @(posedge clk); #1;
            if (got) begin wd[oh2idx(er[c])] = mk(int'(oh2idx(er[c])), seq); seq++; end
        end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] vi [9] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
        logic [NR-1:0] er [9] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b000};
        logic          rs [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [SW+WW-1:0] held = '0;
        logic got = 1'b0, have = 1'b0;
        for (int c = 0; c < 9; c++) begin
            valid_i = vi[c]; ready_i = 1'b1; rst = rs[c];
            @(negedge clk);
            if (got) begin held = sb.pop_front(); have = 1'b1; end
            checks++;
            if (have ? ({valid_o, src_o, wdata_o} !== {1'b1, held}) : (valid_o !== 1'b0)) begin
                errors++; $display("FAIL rstmid_out c%0d got v=%0b src=%0d data=%h exp v=%0b src/data=%h", c, valid_o, src_o, wdata_o, have, held);
            end
            checks++;
            if (ready_o !== er[c]) begin errors++; $display("FAIL rstmid_ready c%0d got %b exp %b", c, ready_o, er[c]); end
            got = (er[c] != '0);
            if (got) sb.push_back({oh2idx(er[c]), wd[oh2idx(er[c])]});
            if (rs[c] || !got) have = 1'b0;
            @(posedge clk); #1;
            if (got) begin wd[oh2idx(er[c])] = mk(int'(oh2idx(er[c])), seq); seq++; end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) wd[i] = mk(i, 16'h30 + i);
        wd[REQ_WHIT] = mk(int'(REQ_WHIT), 8'h77);
        test_reset();
        test_priority();
        test_round_robin();
        test_aging();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d entries exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
